// File: rtl/zktc_bus_pkg.sv
// Shared bus types and constants for the core memory port and its arbiter.
package zktc_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int STRB_W = 2;

  // Returned on a watchdog abort so that a stalled instruction fetch traps.
  localparam logic [DATA_W-1:0] TRAP_OPCODE = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } bus_req_t;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-way round-robin selector: on contention, the master that was not granted last wins.
module mem_arb_rr_pick (
  input  logic v0,
  input  logic v1,
  input  logic last_grant,
  output logic any,
  output logic winner
);

  always_comb begin
    any    = v0 | v1;
    winner = 1'b0;
    if (v0 && v1) begin
      winner = ~last_grant;
    end else if (v1) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the core and a second bus master,
// with a watchdog that aborts hung accesses and hands back the trap opcode.
module mem_arbiter
  import zktc_bus_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_valid,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              bus_err,
  output logic              grant
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  arb_state_t      state_q;
  arb_state_t      state_d;
  bus_req_t        req_q;
  logic            grant_q;
  logic [WD_W-1:0] wdog_q;

  logic            pick_any;
  logic            pick_winner;
  logic            latch_en;
  logic            complete;
  logic            timeout;
  logic            expired;
  logic [DATA_W-1:0] rsp_data;

  function automatic logic [WD_W-1:0] wdog_sat_inc(input logic [WD_W-1:0] w);
    if (w == {WD_W{1'b1}}) begin
      return w;
    end
    return w + 1'b1;
  endfunction

  mem_arb_rr_pick u_pick (
    .v0         (m0_valid),
    .v1         (m1_valid),
    .last_grant (grant_q),
    .any        (pick_any),
    .winner     (pick_winner)
  );

  assign expired = (wdog_q == WD_W'(TIMEOUT));

  // Next-state and completion decode; s_ready wins over a coincident expiry.
  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    complete = 1'b0;
    timeout  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          latch_en = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (s_ready) begin
          complete = 1'b1;
          state_d  = DONE;
        end else if (expired) begin
          complete = 1'b1;
          timeout  = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant-time capture of the winning request; grant resets to 1 so master 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= 1'b1;
      req_q   <= '0;
      wdog_q  <= '0;
    end else if (latch_en) begin
      grant_q <= pick_winner;
      req_q   <= pick_winner ? bus_req_t'{m1_addr, m1_wdata, m1_wstrb}
                             : bus_req_t'{m0_addr, m0_wdata, m0_wstrb};
      wdog_q  <= '0;
    end else if (state_q == BUSY) begin
      wdog_q  <= wdog_sat_inc(wdog_q);
    end
  end

  assign s_valid  = (state_q == BUSY);
  assign s_addr   = req_q.addr;
  assign s_wdata  = req_q.wdata;
  assign s_wstrb  = req_q.wstrb;
  assign grant    = grant_q;
  assign bus_err  = timeout;
  assign rsp_data = timeout ? TRAP_OPCODE : s_rdata;

  assign m0_ready = complete && !grant_q;
  assign m1_ready = complete &&  grant_q;
  assign m0_rdata = m0_ready ? rsp_data : '0;
  assign m1_rdata = m1_ready ? rsp_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a queue of expected responses is checked by a monitor.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic [15:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
  logic [1:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic        m0_ready, m1_ready;
  logic [15:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [15:0] s_addr, s_wdata;
  logic [1:0]  s_wstrb;
  logic        s_ready = 1'b0;
  logic [15:0] s_rdata = '0;
  logic        bus_err, grant;

  typedef struct {
    bit          m;
    logic [15:0] rdata;
    bit          err;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  wstrb;
  } exp_t;

  exp_t        exp_q[$];
  int          rdy_q[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          vcnt = 0;
  int          rise_cyc = 0;
  int          mem_lat = 2;
  logic [15:0] mem_xor = '0;

  mem_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .bus_err(bus_err), .grant(grant)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory: answers on the mem_lat-th cycle of s_valid with s_addr ^ mem_xor; 0 = never.
  always @(posedge clk) begin
    #1;
    if (s_valid) begin
      vcnt++;
      if (vcnt == 1) rise_cyc = cyc;
    end else begin
      vcnt = 0;
    end
    s_ready = s_valid && (mem_lat != 0) && (vcnt == mem_lat);
    s_rdata = s_ready ? (s_addr ^ mem_xor) : 16'h0000;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (m0_ready || m1_ready) begin
        chk("single_ready", {31'b0, m0_ready && m1_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: m0_ready=%b m1_ready=%b required none", m0_ready, m1_ready);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_master", {31'b0, m1_ready}, {31'b0, mon_e.m});
          chk("rsp_rdata", m1_ready ? m1_rdata : m0_rdata, mon_e.rdata);
          chk("rsp_bus_err", {31'b0, bus_err}, {31'b0, mon_e.err});
          chk("rsp_s_addr", s_addr, mon_e.addr);
          chk("rsp_s_wdata", s_wdata, mon_e.wdata);
          chk("rsp_s_wstrb", s_wstrb, mon_e.wstrb);
          rdy_q.push_back(cyc);
        end
      end else begin
        chk("bus_err_without_ready", {31'b0, bus_err}, 32'd0);
      end
      if (!m0_ready) chk("m0_rdata_zero", m0_rdata, 16'h0000);
      if (!m1_ready) chk("m1_rdata_zero", m1_rdata, 16'h0000);
    end
  end

  task automatic push_exp(input bit m, input logic [15:0] rd, input bit err,
                          input logic [15:0] a, input logic [15:0] d, input logic [1:0] st);
    exp_t e;
    e.m = m; e.rdata = rd; e.err = err; e.addr = a; e.wdata = d; e.wstrb = st;
    exp_q.push_back(e);
  endtask

  task automatic wait_ready(input bit m, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m ? m1_ready : m0_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_wait_m%0d: got no ready within 40 cycles, required a ready pulse", m);
    end
  endtask

  // One transaction from a single master; exp_lat is ready cycle minus first s_valid cycle.
  task automatic run_one(input bit m, input logic [15:0] a, input logic [15:0] d,
                         input logic [1:0] st, input int lat, input logic [15:0] xr,
                         input logic [15:0] exp_rd, input bit exp_err, input int exp_lat,
                         input bit chg);
    bit ok;
    mem_lat = lat;
    mem_xor = xr;
    push_exp(m, exp_rd, exp_err, a, d, st);
    if (m) begin
      m1_addr = a; m1_wdata = d; m1_wstrb = st; m1_valid = 1'b1;
    end else begin
      m0_addr = a; m0_wdata = d; m0_wstrb = st; m0_valid = 1'b1;
    end
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m ? m1_ready : m0_ready) begin
        ok = 1'b1;
        break;
      end
      if (chg && s_valid) begin
        chk("latched_s_addr", s_addr, a);
        chk("latched_s_wdata", s_wdata, d);
        if (m) begin m1_addr = ~a; m1_wdata = ~d; end
        else   begin m0_addr = ~a; m0_wdata = ~d; end
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_wait: got no ready within 40 cycles, required a ready pulse");
    end else begin
      chk("ready_latency", cyc - rise_cyc, exp_lat);
    end
    @(posedge clk);
    #2;
    if (m) m1_valid = 1'b0; else m0_valid = 1'b0;
    @(negedge clk);
    chk("done_s_valid_low", {31'b0, s_valid}, 32'd0);
    chk("done_bus_err_low", {31'b0, bus_err}, 32'd0);
    @(posedge clk);
    #2;
  endtask

  task automatic master_seq(input bit m, input int n);
    bit ok;
    if (m) m1_valid = 1'b1; else m0_valid = 1'b1;
    for (int k = 0; k < n; k++) begin
      wait_ready(m, ok);
      @(posedge clk);
    end
    #2;
    if (m) m1_valid = 1'b0; else m0_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000, required completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_valid", {31'b0, s_valid}, 32'd0);
    chk("rst_s_addr", s_addr, 16'h0000);
    chk("rst_s_wdata", s_wdata, 16'h0000);
    chk("rst_s_wstrb", s_wstrb, 2'b00);
    chk("rst_ready", {30'b0, m1_ready, m0_ready}, 32'd0);
    chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
    chk("rst_grant", {31'b0, grant}, 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #2;

    // Single read with zero-wait memory, then a read from master 1.
    run_one(1'b0, 16'h0000, 16'h0000, 2'b00, 2, 16'hFFFF, 16'hFFFF, 1'b0, 1, 1'b0);
    run_one(1'b1, 16'h1234, 16'h0000, 2'b00, 2, 16'h0F0F, 16'h1D3B, 1'b0, 1, 1'b0);

    // Write latching: master 1 changes addr/data mid-transaction.
    run_one(1'b1, 16'hB002, 16'hBEEF, 2'b11, 4, 16'h0000, 16'hB002, 1'b0, 3, 1'b1);

    // Watchdog abort, then s_ready landing exactly on expiry.
    run_one(1'b0, 16'h0040, 16'h0000, 2'b00, 0, 16'h0000, 16'hFFFF, 1'b1, 8, 1'b0);
    run_one(1'b0, 16'h0042, 16'h0000, 2'b00, 9, 16'h00FF, 16'h00BD, 1'b0, 8, 1'b0);

    // Contention: last grant was 0, so master 1 wins first here: m1, m0, m1, m0.
    mem_lat = 2;
    mem_xor = 16'h1111;
    m0_addr = 16'h0100; m0_wdata = 16'h0000; m0_wstrb = 2'b00;
    m1_addr = 16'h0200; m1_wdata = 16'h0000; m1_wstrb = 2'b00;
    push_exp(1'b1, 16'h1311, 1'b0, 16'h0200, 16'h0000, 2'b00);
    push_exp(1'b0, 16'h1011, 1'b0, 16'h0100, 16'h0000, 2'b00);
    push_exp(1'b1, 16'h1311, 1'b0, 16'h0200, 16'h0000, 2'b00);
    push_exp(1'b0, 16'h1011, 1'b0, 16'h0100, 16'h0000, 2'b00);
    rdy_q.delete();
    fork
      master_seq(1'b0, 2);
      master_seq(1'b1, 2);
    join
    repeat (3) @(posedge clk);
    #2;
    chk("contention_count", rdy_q.size(), 4);
    if (rdy_q.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("contention_period", rdy_q[i] - rdy_q[i-1], 4);
    end

    // Reset during an outstanding master 1 access that memory never answers.
    mem_lat = 0;
    m1_addr = 16'h0300;
    m1_valid = 1'b1;
    for (int i = 0; i < 10 && !s_valid; i++) @(negedge clk);
    chk("rstbusy_started", {31'b0, s_valid}, 32'd1);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rstbusy_s_valid", {31'b0, s_valid}, 32'd0);
    chk("rstbusy_m1_ready", {31'b0, m1_ready}, 32'd0);
    chk("rstbusy_grant", {31'b0, grant}, 32'd1);
    m1_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #2;
    mem_lat = 2;
    mem_xor = 16'h0000;
    m0_addr = 16'h0400;
    m1_addr = 16'h0500;
    push_exp(1'b0, 16'h0400, 1'b0, 16'h0400, 16'h0000, 2'b00);
    push_exp(1'b1, 16'h0500, 1'b0, 16'h0500, 16'h0000, 2'b00);
    fork
      master_seq(1'b0, 1);
      master_seq(1'b1, 1);
    join
    repeat (3) @(posedge clk);
    #2;
    chk("all_responses_seen", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter that shares the core's single 16-bit memory port between the core (master 0) and a second bus master (master 1: DMA/debug loader). It sits between the masters and the memory, speaking the core's valid/ready/wstrb protocol on every side. Arbitration is round-robin and each request is latched at grant. A watchdog terminates hung transactions, returning the trap opcode so a stalled fetch ends in a trap.

## Interface
- TIMEOUT, 255: maximum cycles a granted transaction waits for `s_ready`; legal range 1..65535.
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- m0_valid / m1_valid  in  1  master request; held until that master's ready pulse
- m0_addr / m1_addr  in  16  byte address
- m0_wdata / m1_wdata  in  16  write data
- m0_wstrb / m1_wstrb  in  2  byte write strobes; 2'b00 = read
- m0_ready / m1_ready  out  1  one-cycle completion pulse to that master
- m0_rdata / m1_rdata  out  16  read data, valid while that master's ready is high
- s_valid  out  1  request to memory
- s_addr  out  16  latched address
- s_wdata  out  16  latched write data
- s_wstrb  out  2  latched strobes
- s_ready  in  1  memory completion pulse
- s_rdata  in  16  memory read data
- bus_err  out  1  one-cycle pulse on timeout
- grant  out  1  current/last granted master index (debug)

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, any `mX_valid` high: pick the winner and latch its addr/wdata/wstrb into `s_*`. Go to BUSY, clear the watchdog and update `grant`.
  - Winner when both request: the master other than `grant`, i.e. round-robin.
  - Winner when one requests: that master.
- BUSY: `s_valid`=1 and `s_*` come from the latches. Master inputs are ignored, so master-side changes during BUSY have no effect.
- BUSY, `s_ready`=1:
  - `m<grant>_ready`=1 and `m<grant>_rdata`=`s_rdata`, both combinational in the same cycle.
  - Go to DONE.
- BUSY, watchdog reaches TIMEOUT without `s_ready`:
  - `m<grant>_ready`=1 and `m<grant>_rdata`=16'hFFFF (trap opcode); `bus_err`=1.
  - `s_valid` drops next cycle; go to DONE.
- BUSY, `s_ready` in the same cycle the watchdog expires: this is a normal completion. `bus_err` stays 0.
- DONE: one-cycle dead slot with `s_valid`=0 and all requests ignored; then IDLE. This lets the master drop valid and memory drop ready.
- Non-granted master: `ready`=0 and `rdata`=16'h0000 at all times.
- `s_ready` in IDLE or DONE is ignored.
- Watchdog width is $clog2(TIMEOUT+1) bits. It counts BUSY cycles from 0 and saturates; it never wraps.

## Timing
- Reset values:
  - state=IDLE; `grant`=1, so master 0 wins the first contention.
  - `s_valid`=0; `s_addr`, `s_wdata`, `s_rdata` paths = 0; `s_wstrb`=0.
  - `m0_ready`=`m1_ready`=0; `bus_err`=0; watchdog=0.
- Reset asserted mid-BUSY: the transaction is abandoned, no ready pulse is produced, and the state is IDLE immediately.
- Request sampled in IDLE at edge t: `s_valid`=1 from t+1.
- Zero-wait memory that raises `s_ready` one cycle after `s_valid`:
  - `mX_ready` at t+2; DONE at t+3; IDLE at t+4.
  - Minimum period of 4 cycles per transaction.
- Timeout: `bus_err`/ready in the cycle where the watchdog equals TIMEOUT, i.e. TIMEOUT+1 cycles after the grant edge.
- All registered outputs change on `posedge clk`. `mX_ready`, `mX_rdata` and `bus_err` are decoded from registered state plus `s_ready`/`s_rdata`.

## Structure
- Package `zktc_bus_pkg` holds:
  - `ADDR_W`=16, `DATA_W`=16, `STRB_W`=2
  - `TRAP_OPCODE`=16'hFFFF
  - `typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t`
  - `typedef struct packed {addr, wdata, wstrb} bus_req_t`
- Sub-module `mem_arb_rr_pick`: combinational round-robin selector. Inputs: the two valids and last grant. Outputs: `any` and winner index.
- Everything else (FSM, latches, watchdog, muxes) lives in `mem_arbiter`; expected size is about 200 lines.

## Test plan
- **Single read:** `m0` reads 0x0000, memory returns 0xFFFF one cycle later. Expect `m0_ready` pulse with rdata 0xFFFF, `m1_ready`=0, `s_addr`=0x0000 and `s_wstrb`=00.
- **Contention:** both masters request from reset. Expect `m0` served first and `m1` next. With `m0` re-requesting immediately, the order continues `m0`, `m1`, `m0`, `m1`, and each grant is separated by a DONE cycle.
- **Write latching:** `m1` writes 0xBEEF to 0xB002 with wstrb 11, then changes its addr/data during BUSY. Expect `s_addr`=0xB002 and `s_wdata`=0xBEEF throughout the transaction.
- **Timeout:** TIMEOUT=8 and memory never answers. Expect `m0_ready` and `bus_err` 9 cycles after the grant edge, with rdata 0xFFFF; then `s_valid`=0, DONE, IDLE.
- **Ready/timeout coincide:** `s_ready` arrives exactly at expiry. Expect normal completion with memory data and `bus_err`=0.
- **Reset mid-BUSY:** assert `rst` during an outstanding `m1` access. Expect `s_valid`=0 and no ready pulse, then the next contention is granted to `m0`.
